led_frame_buffer: RTL and testbench
===================================

Name: led_frame_buffer

Overview:
Producer side of the 8x8 bicolour LED matrix pixel interface. Game logic writes individual pixels into a back buffer. The back buffer is copied to a front buffer, which drives red_array/green_array of the matrix scan driver. The copy happens only on a commit, synchronised to the driver's end-of-frame pulse, so the display never shows a half-drawn board. The block also provides a back-buffer read port for collision checks, a multi-cycle clear, and a frame counter for game timing.

Parameters:
CLEAR_ROWS_PER_CYCLE, 1, rows zeroed per clock during CLEAR; legal values 1, 2, 4, 8; clear takes 8/CLEAR_ROWS_PER_CYCLE cycles.
FRAME_CNT_W, 8, width of frame_count.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
wr_en  in  1  pixel write strobe
wr_x  in  3  column index of write (bit position within row)
wr_y  in  3  row index of write
wr_color  in  2  00 off, 01 red, 10 green, 11 yellow (red+green)
rd_x  in  3  column index of read
rd_y  in  3  row index of read
rd_color  out  2  back-buffer pixel at (rd_x, rd_y), same encoding as wr_color, combinational
clear_req  in  1  request to zero the entire back buffer
commit_req  in  1  request to copy back buffer to front at next frame boundary
frame_end  in  1  one-cycle pulse from scan driver, asserted in the cycle its row index wraps 7->0
busy  out  1  high in CLEAR and WAIT_SWAP; clear_req, commit_req and wr_en are ignored while high
commit_pending  out  1  high only in WAIT_SWAP
frame_count  out  FRAME_CNT_W  count of frame_end pulses, wraps at max->0
red_array  out  [7:0][7:0]  front buffer red plane, indexed [row][col]
green_array  out  [7:0][7:0]  front buffer green plane, indexed [row][col]

Behaviour:
- Storage: back_red/back_green and front (red_array/green_array) are registers. Bit [y][x] of red gets wr_color[0]; bit [y][x] of green gets wr_color[1].
- Reset (sync, active-high): both buffers all-zero, state IDLE, busy=0, commit_pending=0, frame_count=0, clear row counter=0. Reset mid-CLEAR or mid-WAIT_SWAP aborts the operation, with no partial swap.
- States: IDLE, CLEAR, WAIT_SWAP.
- IDLE priority when several requests arrive in the same cycle: clear_req > commit_req > wr_en. Only the highest-priority request is acted on; lower ones are dropped and not queued.
- Write: in IDLE with wr_en and no clear_req/commit_req, pixel (wr_x, wr_y) is updated at the clock edge. It is visible on rd_color the next cycle. All other pixels are unchanged.
- CLEAR: entered from IDLE on clear_req.
  - Row counter starts at 0 and zeroes CLEAR_ROWS_PER_CYCLE back-buffer rows per cycle, ascending.
  - After the last row, returns to IDLE; busy drops the following cycle.
  - With default parameters, busy is high for exactly 8 cycles.
  - Front buffer is untouched.
- Commit:
  - In IDLE, commit_req with frame_end in the same cycle copies back->front at that edge and stays in IDLE (busy never rises).
  - commit_req without frame_end enters WAIT_SWAP.
  - In WAIT_SWAP, the first frame_end copies back->front at that edge and returns to IDLE.
  - New red_array/green_array values appear the cycle after the frame_end edge.
- Back buffer is never modified by a swap; contents persist for incremental drawing.
- frame_count increments on every frame_end in every state, including WAIT_SWAP, and is independent of commits.
- rd_color always reflects the back buffer, including during CLEAR (partially cleared rows read 00).
- No other output changes except at the clock edge.

Test Plan:
- Reset then write (x=3, y=5, 01) -> rd_color at (3,5)=01 next cycle. red_array stays all-zero until commit. With commit_req+frame_end in one cycle, red_array[5]=8'b00001000 next cycle and green_array all-zero.
- Write (0,0,11) and (7,7,10), commit_req alone -> busy=1, commit_pending=1, front unchanged for 20 cycles. frame_end pulse -> red_array[0][0]=1, green_array[0][0]=1, green_array[7][7]=1, busy=0 one cycle later.
- Fill back buffer with 11 everywhere, then clear_req -> busy high exactly 8 cycles. After 3 cycles rows 0-2 read 00 and row 3 reads 11. After completion all 64 pixels read 00, and the front buffer still shows the prior frame.
- Same cycle: clear_req=1, commit_req=1, wr_en=1 (2,2,01) -> only CLEAR runs. Pixel (2,2) stays 00 and commit_pending never asserts. wr_en during busy=1 -> back buffer unchanged.
- Apply 260 frame_end pulses (some during WAIT_SWAP) -> frame_count=4 (wrap at 255->0).
- Assert reset in the 4th cycle of CLEAR and separately during WAIT_SWAP -> all outputs zero the next cycle, state IDLE, and a subsequent frame_end does not swap.

Source files
------------

// File: rtl/led_frame_buffer_if.sv
// Pixel/control bundle between game logic, the LED matrix scan driver and
// the led_frame_buffer block. Game logic and scan driver sit on the master
// side; the frame buffer itself is the slave.
interface led_frame_buffer_if #(
   parameter int FRAME_CNT_W = 8
) ();
   logic                   wr_en;
   logic [2:0]             wr_x;
   logic [2:0]             wr_y;
   logic [1:0]             wr_color;
   logic [2:0]             rd_x;
   logic [2:0]             rd_y;
   logic [1:0]             rd_color;
   logic                   clear_req;
   logic                   commit_req;
   logic                   frame_end;
   logic                   busy;
   logic                   commit_pending;
   logic [FRAME_CNT_W-1:0] frame_count;
   logic [7:0][7:0]        red_array;
   logic [7:0][7:0]        green_array;

   modport master (
      output wr_en, wr_x, wr_y, wr_color, rd_x, rd_y,
             clear_req, commit_req, frame_end,
      input  rd_color, busy, commit_pending, frame_count,
             red_array, green_array
   );

   modport slave (
      input  wr_en, wr_x, wr_y, wr_color, rd_x, rd_y,
             clear_req, commit_req, frame_end,
      output rd_color, busy, commit_pending, frame_count,
             red_array, green_array
   );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 bicolour frame store. Pixels are drawn into a back
// buffer; a commit copies it to the front buffer only on the scan driver's
// frame_end pulse so the matrix never shows a half-drawn board.
module led_frame_buffer #(
   parameter int CLEAR_ROWS_PER_CYCLE = 1,
   parameter int FRAME_CNT_W          = 8
) (
   input logic               clk,
   input logic               reset,
   led_frame_buffer_if.slave bus
);

   localparam int         CLR_STEPS = 8 / CLEAR_ROWS_PER_CYCLE;
   localparam logic [2:0] CLR_LAST  = 3'(CLR_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CLEAR     = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [7:0][7:0]        back_red_r;
   logic [7:0][7:0]        back_green_r;
   logic [7:0][7:0]        front_red_r;
   logic [7:0][7:0]        front_green_r;
   logic [2:0]             clr_idx_r;
   logic [FRAME_CNT_W-1:0] frame_cnt_r;
   logic [7:0]             clr_row_mask_s;
   logic                   clr_last_s;
   logic                   busy_s;
   logic                   pending_s;
   logic                   do_write_s;
   logic                   do_clear_s;
   logic                   do_swap_s;

   assign clr_last_s = (clr_idx_r == CLR_LAST);

   // Select the block of rows zeroed by the current clear step.
   always_comb begin
      clr_row_mask_s = 8'h00;
      for (int r = 0; r < 8; r++) begin
         if ((r / CLEAR_ROWS_PER_CYCLE) == int'(clr_idx_r)) begin
            clr_row_mask_s[r] = 1'b1;
         end else begin
            clr_row_mask_s[r] = 1'b0;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; clear wins over commit, commit with frame_end swaps at once.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.clear_req) begin
               state_nxt_s = ST_CLEAR;
            end else if (bus.commit_req && !bus.frame_end) begin
               state_nxt_s = ST_WAIT_SWAP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clr_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_WAIT_SWAP: begin
            if (bus.frame_end) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_SWAP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output and datapath-control decode; requests are ignored outside IDLE.
   always_comb begin
      busy_s     = 1'b0;
      pending_s  = 1'b0;
      do_write_s = 1'b0;
      do_clear_s = 1'b0;
      do_swap_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            do_write_s = bus.wr_en && !bus.clear_req && !bus.commit_req;
            do_swap_s  = bus.commit_req && !bus.clear_req && bus.frame_end;
         end
         ST_CLEAR: begin
            busy_s     = 1'b1;
            do_clear_s = 1'b1;
         end
         ST_WAIT_SWAP: begin
            busy_s    = 1'b1;
            pending_s = 1'b1;
            do_swap_s = bus.frame_end;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Clear step counter; parked at zero whenever no clear is running.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_idx_r <= 3'd0;
      end else if (do_clear_s && !clr_last_s) begin
         clr_idx_r <= clr_idx_r + 3'd1;
      end else begin
         clr_idx_r <= 3'd0;
      end
   end

   // Back buffer: row-block clear or single-pixel write.
   always_ff @(posedge clk) begin
      if (reset) begin
         back_red_r   <= 64'h0;
         back_green_r <= 64'h0;
      end else if (do_clear_s) begin
         for (int r = 0; r < 8; r++) begin
            if (clr_row_mask_s[r]) begin
               back_red_r[r]   <= 8'h00;
               back_green_r[r] <= 8'h00;
            end
         end
      end else if (do_write_s) begin
         back_red_r[bus.wr_y][bus.wr_x]   <= bus.wr_color[0];
         back_green_r[bus.wr_y][bus.wr_x] <= bus.wr_color[1];
      end
   end

   // Front buffer: whole-frame copy on a frame-aligned commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         front_red_r   <= 64'h0;
         front_green_r <= 64'h0;
      end else if (do_swap_s) begin
         front_red_r   <= back_red_r;
         front_green_r <= back_green_r;
      end
   end

   // Free-running frame counter for game timing, independent of state.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_r <= {FRAME_CNT_W{1'b0}};
      end else if (bus.frame_end) begin
         frame_cnt_r <= frame_cnt_r + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.rd_color       = {back_green_r[bus.rd_y][bus.rd_x], back_red_r[bus.rd_y][bus.rd_x]};
   assign bus.busy           = busy_s;
   assign bus.commit_pending = pending_s;
   assign bus.frame_count    = frame_cnt_r;
   assign bus.red_array      = front_red_r;
   assign bus.green_array    = front_green_r;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer. Stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_led_frame_buffer;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   led_frame_buffer_if #(.FRAME_CNT_W(8)) bus ();

   led_frame_buffer #(
      .CLEAR_ROWS_PER_CYCLE(1),
      .FRAME_CNT_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   localparam int K_RD    = 0;
   localparam int K_BUSY  = 1;
   localparam int K_PEND  = 2;
   localparam int K_FCNT  = 3;
   localparam int K_RED   = 4;
   localparam int K_GREEN = 5;

   typedef struct {
      int          cyc;
      int          kind;
      logic [63:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc_cnt = 0;
   int   total   = 0;
   int   bad     = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [63:0] observe(int kind);
      case (kind)
         K_RD:    return {62'd0, bus.rd_color};
         K_BUSY:  return {63'd0, bus.busy};
         K_PEND:  return {63'd0, bus.commit_pending};
         K_FCNT:  return {56'd0, bus.frame_count};
         K_RED:   return bus.red_array;
         K_GREEN: return bus.green_array;
         default: return {64{1'b1}};
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         e   = sb.pop_front();
         act = observe(e.kind);
         total++;
         if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act, e.exp, cyc_cnt);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(int kind, logic [63:0] v, string nm);
      sb.push_back('{cyc_cnt, kind, v, nm});
   endtask

   task automatic rd(logic [2:0] x, logic [2:0] y);
      bus.rd_x = x;
      bus.rd_y = y;
   endtask

   task automatic wr(logic [2:0] x, logic [2:0] y, logic [1:0] c);
      bus.wr_en    = 1'b1;
      bus.wr_x     = x;
      bus.wr_y     = y;
      bus.wr_color = c;
      tick();
      bus.wr_en    = 1'b0;
   endtask

   function automatic logic [63:0] bit_at(int x, int y);
      logic [63:0] one;
      one = 64'd1;
      return one << (y * 8 + x);
   endfunction

   logic [63:0] exp_red2;
   logic [63:0] exp_grn2;

   initial begin
      reset          = 1'b1;
      bus.wr_en      = 1'b0;
      bus.wr_x       = 3'd0;
      bus.wr_y       = 3'd0;
      bus.wr_color   = 2'b00;
      bus.rd_x       = 3'd0;
      bus.rd_y       = 3'd0;
      bus.clear_req  = 1'b0;
      bus.commit_req = 1'b0;
      bus.frame_end  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk(K_BUSY, 64'd0, "rst_busy");
      chk(K_PEND, 64'd0, "rst_pending");
      chk(K_FCNT, 64'd0, "rst_fcount");
      chk(K_RED, 64'd0, "rst_red");
      chk(K_GREEN, 64'd0, "rst_green");

      // Single write then immediate frame-aligned commit.
      rd(3'd3, 3'd5);
      wr(3'd3, 3'd5, 2'b01);
      chk(K_RD, 64'd1, "t1_rd_after_write");
      chk(K_RED, 64'd0, "t1_red_before_commit");
      bus.commit_req = 1'b1;
      bus.frame_end  = 1'b1;
      tick();
      bus.commit_req = 1'b0;
      bus.frame_end  = 1'b0;
      chk(K_RED, bit_at(3, 5), "t1_red_after_commit");
      chk(K_GREEN, 64'd0, "t1_green_after_commit");
      chk(K_BUSY, 64'd0, "t1_busy_never");
      chk(K_FCNT, 64'd1, "t1_fcount");
      chk(K_RD, 64'd1, "t1_back_persists");

      // Commit that waits for a frame boundary.
      wr(3'd0, 3'd0, 2'b11);
      wr(3'd7, 3'd7, 2'b10);
      bus.commit_req = 1'b1;
      tick();
      bus.commit_req = 1'b0;
      chk(K_BUSY, 64'd1, "t2_busy");
      chk(K_PEND, 64'd1, "t2_pending");
      chk(K_RED, bit_at(3, 5), "t2_red_held");
      for (int i = 0; i < 20; i++) begin
         tick();
         chk(K_RED, bit_at(3, 5), "t2_red_hold");
         chk(K_PEND, 64'd1, "t2_pending_hold");
      end
      bus.frame_end = 1'b1;
      tick();
      bus.frame_end = 1'b0;
      exp_red2 = bit_at(3, 5) | bit_at(0, 0);
      exp_grn2 = bit_at(0, 0) | bit_at(7, 7);
      chk(K_RED, exp_red2, "t2_red_swapped");
      chk(K_GREEN, exp_grn2, "t2_green_swapped");
      chk(K_BUSY, 64'd0, "t2_busy_done");
      chk(K_PEND, 64'd0, "t2_pending_done");
      chk(K_FCNT, 64'd2, "t2_fcount");

      // Fill with yellow, then a multi-cycle clear.
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            wr(3'(x), 3'(y), 2'b11);
         end
      end
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) tick();
         if (k == 0) begin
            rd(3'd2, 3'd0);
            chk(K_RD, 64'd3, "t3_row0_not_yet");
         end else if (k == 3) begin
            rd(3'd5, 3'd3);
            chk(K_RD, 64'd3, "t3_row3_still_set");
         end else if (k == 8) begin
            rd(3'd1, 3'd7);
            chk(K_RD, 64'd0, "t3_row7_cleared");
         end else begin
            rd(3'(k), 3'(k - 1));
            chk(K_RD, 64'd0, "t3_row_cleared");
         end
         chk(K_BUSY, (k < 8) ? 64'd1 : 64'd0, "t3_busy_window");
         if (k == 5) begin
            bus.wr_en    = 1'b1;
            bus.wr_x     = 3'd1;
            bus.wr_y     = 3'd1;
            bus.wr_color = 2'b11;
         end else begin
            bus.wr_en = 1'b0;
         end
      end
      chk(K_RED, exp_red2, "t3_front_red_kept");
      chk(K_GREEN, exp_grn2, "t3_front_green_kept");
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            rd(3'(x), 3'(y));
            chk(K_RD, 64'd0, "t3_all_zero");
            tick();
         end
      end

      // Simultaneous clear, commit and write: only the clear runs.
      rd(3'd2, 3'd2);
      bus.clear_req  = 1'b1;
      bus.commit_req = 1'b1;
      bus.wr_en      = 1'b1;
      bus.wr_x       = 3'd2;
      bus.wr_y       = 3'd2;
      bus.wr_color   = 2'b01;
      tick();
      bus.clear_req  = 1'b0;
      bus.commit_req = 1'b0;
      bus.wr_en      = 1'b0;
      for (int k = 0; k < 9; k++) begin
         chk(K_BUSY, (k < 8) ? 64'd1 : 64'd0, "t4_busy_window");
         chk(K_PEND, 64'd0, "t4_no_pending");
         chk(K_RD, 64'd0, "t4_pixel_not_written");
         tick();
      end
      chk(K_RED, exp_red2, "t4_front_unchanged");

      // Frame counter wrap across waits and swaps.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk(K_FCNT, 64'd0, "t5_fcount_reset");
      chk(K_RED, 64'd0, "t5_red_reset");
      wr(3'd4, 3'd4, 2'b01);
      bus.commit_req = 1'b1;
      tick();
      bus.commit_req = 1'b0;
      chk(K_PEND, 64'd1, "t5_wait_initial");
      for (int i = 1; i <= 260; i++) begin
         bus.frame_end = 1'b1;
         tick();
         bus.frame_end = 1'b0;
         if (i == 1) begin
            chk(K_RED, bit_at(4, 4), "t5_swap_first_pulse");
            chk(K_PEND, 64'd0, "t5_pending_cleared");
         end
         if (i == 255) chk(K_FCNT, 64'd255, "t5_fcount_max");
         if (i == 256) chk(K_FCNT, 64'd0, "t5_fcount_wrap");
         if (i % 100 == 0) bus.commit_req = 1'b1;
         tick();
         bus.commit_req = 1'b0;
         if (i % 100 == 0) chk(K_PEND, 64'd1, "t5_wait_again");
      end
      chk(K_FCNT, 64'd4, "t5_fcount_final");
      chk(K_PEND, 64'd0, "t5_pending_final");
      chk(K_RED, bit_at(4, 4), "t5_red_final");

      // Reset in the fourth cycle of a clear.
      wr(3'd6, 3'd1, 2'b11);
      bus.commit_req = 1'b1;
      bus.frame_end  = 1'b1;
      tick();
      bus.commit_req = 1'b0;
      bus.frame_end  = 1'b0;
      chk(K_GREEN, bit_at(6, 1), "t6_green_loaded");
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      tick();
      tick();
      tick();
      chk(K_BUSY, 64'd1, "t6_busy_in_clear");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd(3'd6, 3'd1);
      chk(K_BUSY, 64'd0, "t6a_busy");
      chk(K_PEND, 64'd0, "t6a_pending");
      chk(K_FCNT, 64'd0, "t6a_fcount");
      chk(K_RED, 64'd0, "t6a_red");
      chk(K_GREEN, 64'd0, "t6a_green");
      chk(K_RD, 64'd0, "t6a_back");
      bus.frame_end = 1'b1;
      tick();
      bus.frame_end = 1'b0;
      chk(K_RED, 64'd0, "t6a_no_swap");
      chk(K_FCNT, 64'd1, "t6a_fcount_pulse");

      // Reset while waiting for a swap.
      wr(3'd2, 3'd6, 2'b11);
      bus.commit_req = 1'b1;
      tick();
      bus.commit_req = 1'b0;
      chk(K_PEND, 64'd1, "t6b_pending");
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd(3'd2, 3'd6);
      chk(K_BUSY, 64'd0, "t6b_busy");
      chk(K_PEND, 64'd0, "t6b_pending_cleared");
      chk(K_FCNT, 64'd0, "t6b_fcount");
      chk(K_RD, 64'd0, "t6b_back");
      bus.frame_end = 1'b1;
      tick();
      bus.frame_end = 1'b0;
      chk(K_RED, 64'd0, "t6b_red_no_swap");
      chk(K_GREEN, 64'd0, "t6b_green_no_swap");
      chk(K_BUSY, 64'd0, "t6b_busy_after");
      chk(K_FCNT, 64'd1, "t6b_fcount_pulse");

      tick();
      tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
